// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator feeding an order-preserving ready/valid output FIFO.
// Optional feature: define IMM_GEN_ZIMM_EN to decode fmt 5 as the CSR zimm.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [2:0]      fmt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic            fmt_err,
   output logic [7:0]      err_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef logic [XLEN-1:0] imm_t;

   function automatic imm_t sext32(input logic signed [31:0] v);
      return XLEN'(v);
   endfunction

   function automatic logic fmt_illegal(input logic [2:0] f);
`ifdef IMM_GEN_ZIMM_EN
      return (f > 3'd5);
`else
      return (f > 3'd4);
`endif
   endfunction

   function automatic imm_t build_imm(input logic [31:0] ins, input logic [2:0] f);
      imm_t r;
      r = '0;
      case (f)
         3'd0: r = sext32(32'($signed(ins[31:20])));
         3'd1: r = sext32(32'($signed({ins[31:25], ins[11:7]})));
         3'd2: r = sext32(32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})));
         3'd3: r = sext32({ins[31:12], 12'b0});
         3'd4: r = sext32(32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})));
`ifdef IMM_GEN_ZIMM_EN
         3'd5: r = XLEN'(ins[19:15]);
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   logic            rdy_q, rdy_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
   imm_t            hold_imm_q, hold_imm_d;
   logic            hold_err_q, hold_err_d;
   imm_t            mem_imm_q [DEPTH];
   logic            mem_err_q [DEPTH];
   logic            push, pop;
   imm_t            new_imm;
   logic            new_err;

   assign new_imm   = build_imm(instr, fmt);
   assign new_err   = fmt_illegal(fmt);
   // rdy_q keeps in_ready low until the first edge after reset release
   assign in_ready  = rdy_q & (cnt_q != FULL);
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // With the FIFO empty the last popped head is replayed, so imm holds its value
   assign imm       = out_valid ? mem_imm_q[rd_ptr_q] : hold_imm_q;
   assign fmt_err   = out_valid ? mem_err_q[rd_ptr_q] : hold_err_q;
   assign err_cnt   = err_cnt_q;

   always_comb begin
      rdy_d      = 1'b1;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      err_cnt_d  = err_cnt_q;
      hold_imm_d = hold_imm_q;
      hold_err_d = hold_err_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (new_err) err_cnt_d = sat_inc(err_cnt_q);
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         hold_imm_d = mem_imm_q[rd_ptr_q];
         hold_err_d = mem_err_q[rd_ptr_q];
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         err_cnt_q  <= '0;
         hold_imm_q <= '0;
         hold_err_q <= 1'b0;
      end else begin
         rdy_q      <= rdy_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         err_cnt_q  <= err_cnt_d;
         hold_imm_q <= hold_imm_d;
         hold_err_q <= hold_err_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_imm_q[wr_ptr_q] <= new_imm;
         mem_err_q[wr_ptr_q] <= new_err;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance driven in lockstep.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [2:0]  fmt;

   logic        ir32, ov32, fe32;
   logic [31:0] imm32;
   logic [7:0]  ec32;
   logic        ir64, ov64, fe64;
   logic [63:0] imm64;
   logic [7:0]  ec64;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_ec  = 8'd0;

   logic [31:0] st_ins [4] = '{32'h7FF00013, 32'h80000013, 32'h12300013, 32'hFFE00013};
   logic [63:0] st_exp [4] = '{64'h7FF, 64'hFFFF_FFFF_FFFF_F800, 64'h123, 64'hFFFF_FFFF_FFFF_FFFE};

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
      .instr(instr), .fmt(fmt), .out_valid(ov32), .out_ready(out_ready),
      .imm(imm32), .fmt_err(fe32), .err_cnt(ec32)
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
      .instr(instr), .fmt(fmt), .out_valid(ov64), .out_ready(out_ready),
      .imm(imm64), .fmt_err(fe64), .err_cnt(ec64)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sat8(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [63:0] exp, input logic e);
      chk({tag, "_imm32"}, {32'b0, imm32}, {32'b0, exp[31:0]});
      chk({tag, "_imm64"}, imm64, exp);
      chk({tag, "_err"}, {62'b0, fe32, fe64}, {62'b0, e, e});
      chk({tag, "_ecnt"}, {48'b0, ec32, ec64}, {48'b0, exp_ec, exp_ec});
   endtask

   task automatic xfer(input string tag, input logic [31:0] ins, input logic [2:0] f,
                       input logic [63:0] exp, input logic e);
      instr     = ins;
      fmt       = f;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step;
      in_valid = 1'b0;
      if (e) exp_ec = sat8(exp_ec);
      chk({tag, "_vld"}, {62'b0, ov32, ov64}, 64'd3);
      chk_head(tag, exp, e);
      step;
      chk({tag, "_drain"}, {62'b0, ov32, ov64}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      instr     = '0;
      fmt       = '0;
      #2;
      chk("rst_vld", {62'b0, ov32, ov64}, 64'd0);
      chk("rst_rdy", {62'b0, ir32, ir64}, 64'd0);
      chk_head("rst", 64'd0, 1'b0);
      step;
      step;
      chk("rst_hold_rdy", {62'b0, ir32, ir64}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_rdy_pre", {62'b0, ir32, ir64}, 64'd0);
      step;
      chk("rel_rdy_post", {62'b0, ir32, ir64}, 64'd3);

      xfer("i_neg", 32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      xfer("i_pos", 32'h00100093, 3'd0, 64'h1, 1'b0);
      xfer("s_pos", 32'h00A02423, 3'd1, 64'h8, 1'b0);
      xfer("s_neg", 32'h80000000, 3'd1, 64'hFFFF_FFFF_FFFF_F800, 1'b0);
      xfer("b_neg", 32'hFE000EE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      xfer("u_pos", 32'h12345037, 3'd3, 64'h1234_5000, 1'b0);
      xfer("u_neg", 32'h80000037, 3'd3, 64'hFFFF_FFFF_8000_0000, 1'b0);
      xfer("j_pos", 32'h0080006F, 3'd4, 64'h8, 1'b0);
      xfer("j_neg", 32'hFFDFF06F, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      xfer("ill6", 32'hFFFFFFFF, 3'd6, 64'h0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
      xfer("zimm", 32'h000F8073, 3'd5, 64'h1F, 1'b0);
`else
      xfer("zimm", 32'h000F8073, 3'd5, 64'h0, 1'b1);
`endif

      // Back-pressure: fill to full, hold a third beat, then drain in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr = 32'h00100093; fmt = 3'd0;
      step;
      chk("full1_rdy", {62'b0, ir32, ir64}, 64'd3);
      chk_head("full1", 64'h1, 1'b0);
      instr = 32'h12345037; fmt = 3'd3;
      step;
      chk("full2_rdy", {62'b0, ir32, ir64}, 64'd0);
      chk_head("full2", 64'h1, 1'b0);
      instr = 32'h00A02423; fmt = 3'd1;
      step;
      chk("full3_rdy", {62'b0, ir32, ir64}, 64'd0);
      chk_head("full3", 64'h1, 1'b0);
      out_ready = 1'b1;
      step;
      chk("drain1_rdy", {62'b0, ir32, ir64}, 64'd3);
      chk_head("drain1", 64'h1234_5000, 1'b0);
      step;
      in_valid = 1'b0;
      chk("drain2_vld", {62'b0, ov32, ov64}, 64'd3);
      chk_head("drain2", 64'h8, 1'b0);
      step;
      chk("drain3_vld", {62'b0, ov32, ov64}, 64'd0);
      chk_head("empty_hold", 64'h8, 1'b0);
      step;
      chk("empty_vld", {62'b0, ov32, ov64}, 64'd0);
      chk_head("empty_hold2", 64'h8, 1'b0);

      // Streaming: simultaneous push/pop every cycle across pointer wraps
      in_valid = 1'b1;
      fmt      = 3'd0;
      for (int k = 0; k < 4; k++) begin
         instr = st_ins[k];
         step;
         chk($sformatf("stream%0d_rdy", k), {62'b0, ir32, ir64}, 64'd3);
         chk_head($sformatf("stream%0d", k), st_exp[k], 1'b0);
      end
      in_valid = 1'b0;
      step;
      chk("stream_end_vld", {62'b0, ov32, ov64}, 64'd0);

      // Illegal-format flood: err_cnt saturates
      in_valid = 1'b1;
      instr    = 32'hFFFFFFFF;
      fmt      = 3'd7;
      for (int k = 0; k < 300; k++) begin
         step;
         exp_ec = sat8(exp_ec);
         chk_head($sformatf("sat%0d", k), 64'h0, 1'b1);
      end
      in_valid = 1'b0;
      step;
      chk("sat_final", {48'b0, ec32, ec64}, {48'b0, 16'hFFFF});

      // Asynchronous reset with the FIFO full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr = 32'h00100093; fmt = 3'd0;
      step;
      step;
      in_valid = 1'b0;
      chk("arst_full_rdy", {62'b0, ir32, ir64}, 64'd0);
      chk("arst_full_vld", {62'b0, ov32, ov64}, 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      exp_ec = 8'd0;
      chk("arst_vld", {62'b0, ov32, ov64}, 64'd0);
      chk("arst_rdy", {62'b0, ir32, ir64}, 64'd0);
      chk_head("arst", 64'h0, 1'b0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("arst_rel_pre", {62'b0, ir32, ir64}, 64'd0);
      step;
      chk("arst_rel_post", {62'b0, ir32, ir64}, 64'd3);
      chk("arst_rel_vld", {62'b0, ov32, ov64}, 64'd0);
      xfer("post_rst", 32'hFFDFF06F, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the output FIFO entry count; legal values are powers of two, 2 to 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the instruction beat is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-007 The block SHALL have port instr, input, 32 bits: the raw RV32/RV64 instruction word.
REQ-008 The block SHALL have port fmt, input, 3 bits: the immediate format (0=I, 1=S, 2=B, 3=U, 4=J, 5=Z, 6/7=illegal).
REQ-009 The block SHALL have port out_valid, output, 1 bit: the FIFO head holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head.
REQ-011 The block SHALL have port imm, output, XLEN bits: the extended immediate at the FIFO head.
REQ-012 The block SHALL have port fmt_err, output, 1 bit: the head beat had an illegal fmt.
REQ-013 The block SHALL have port err_cnt, output, 8 bits: a saturating count of illegal-fmt beats accepted.

Function
REQ-014 Accept SHALL occur when in_valid and in_ready are both high on a clock edge; pop SHALL occur when out_valid and out_ready are both high.
REQ-015 Immediate assembly:
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
- U = {instr[31:12], 12'b0}
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
REQ-016 Formats I, S, B and J SHALL be sign-extended from their top bit to XLEN; U SHALL be sign-extended from bit 31 (this matters for XLEN=64).
REQ-017 fmt 6/7 SHALL store imm=0 and fmt_err=1; legal formats SHALL store fmt_err=0.
REQ-018 The result SHALL be computed combinationally from the accepted beat and written into the FIFO on the accept edge; out_valid SHALL assert on that edge when the FIFO was empty (latency 1 cycle).
REQ-019 The FIFO SHALL preserve order, use wrapping read/write pointers of width log2(DEPTH), and keep a count of 0..DEPTH.
REQ-020 in_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0).
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 At full, in_ready SHALL be 0 and no beat SHALL be written; at empty, imm SHALL hold its last value and out_ready SHALL be ignored.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no bubble.
REQ-024 err_cnt SHALL increment by 1 on each accepted illegal-fmt beat and SHALL saturate at 8'hFF.

Reset
REQ-025 While rst_n=0: count=0, both pointers=0, out_valid=0, in_ready=0, imm=0, fmt_err=0, err_cnt=0.
REQ-026 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents immediately, without waiting for a clock edge.

Configuration
REQ-028 With macro IMM_GEN_ZIMM_EN defined, fmt 5 (Z) SHALL produce the zero-extended {XLEN-5 zeros, instr[19:15]} (the CSR zimm) with fmt_err=0.
REQ-029 Without IMM_GEN_ZIMM_EN, fmt 5 SHALL be treated as illegal per REQ-017 and REQ-024.

Verification
REQ-030 Scenario: XLEN=32, fmt=0, instr=32'hFFF00093, out_ready=1 -> one cycle later out_valid=1, imm=32'hFFFFFFFF, fmt_err=0.
REQ-031 Scenario: fmt=2, instr=32'hFE000EE3 -> imm=32'hFFFFFFFC; fmt=3, instr=32'h12345037 -> imm=32'h12345000.
REQ-032 Scenario: DEPTH=2, out_ready=0, three back-to-back beats -> two accepted, then in_ready=0 and the third is held; raise out_ready -> imm values emerge in order, with no loss or duplication.
REQ-033 Scenario: 300 accepted beats with fmt=7 -> each has imm=0, fmt_err=1; err_cnt stops at 8'hFF.
REQ-034 Scenario: with the FIFO full, pulse rst_n low between edges -> out_valid=0 and err_cnt=0 immediately; in_ready=1 one edge after release.
REQ-035 Scenario: XLEN=64 with IMM_GEN_ZIMM_EN defined, fmt=5, instr=32'h000F8073 -> imm=64'h1F; without the macro -> imm=0, fmt_err=1.
